permute_unit_core: RTL and testbench

//  AltiVec vector permute unit (VPU-class execution pipe) of the vector core. Executes

---
 rtl/permute_unit_core_if.sv | 36 +++
 rtl/permute_unit_core.sv | 195 +++++++++++++++++++
 tb/tb_permute_unit_core.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/permute_unit_core_if.sv
// ----------------------------------------------------------------------------
// permute_unit_core_if : issue/result bundle of the vector permute unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface permute_unit_core_if;
  logic         in_PU_cs;
  logic [5:0]   in_PUType;
  logic [127:0] in_PUAOperand;
  logic [127:0] in_PUBOperand;
  logic [127:0] in_PUCOperand;
  logic [4:0]   in_PUTargetRegister;
  logic         out_PUTargetRegisterEnable;
  logic [4:0]   out_PUTargetRegister;
  logic [127:0] out_PUResult;
  logic [4:0]   out_PUTargetRegisterPipe;
  logic         out_PUtoVSCREnable;
  logic [31:0]  out_PUtoVSCR;

  modport master (
    output in_PU_cs, in_PUType, in_PUAOperand, in_PUBOperand, in_PUCOperand,
           in_PUTargetRegister,
    input  out_PUTargetRegisterEnable, out_PUTargetRegister, out_PUResult,
           out_PUTargetRegisterPipe, out_PUtoVSCREnable, out_PUtoVSCR
  );

  modport slave (
    input  in_PU_cs, in_PUType, in_PUAOperand, in_PUBOperand, in_PUCOperand,
           in_PUTargetRegister,
    output out_PUTargetRegisterEnable, out_PUTargetRegister, out_PUResult,
           out_PUTargetRegisterPipe, out_PUtoVSCREnable, out_PUtoVSCR
  );
endinterface

`default_nettype wire

// File: rtl/permute_unit_core.sv
// ----------------------------------------------------------------------------
// permute_unit_core : AltiVec permute/merge/splat/shift/pack/unpack pipe,
// one op per cycle, result registered one cycle after issue.
// Optional macro PU_PIXEL_OPS_EN enables vpkpx / vupkhpx / vupklpx.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module permute_unit_core (
  input  logic               clk,
  input  logic               rst_n,
  permute_unit_core_if.slave pu
);

  logic [127:0] va, vb, vc;
  logic [5:0]   op;
  logic [255:0] ab, ab_sh;
  logic [127:0] res;
  logic         sat, supported, sat_op;
  logic [1:0]   pk_mode;
  logic [8:0]   ph;
  logic [16:0]  pw;
  logic [15:0]  hx;

  logic         en_q, vscr_en_q, sat_q;
  logic [4:0]   tgt_q;
  logic [127:0] res_q;

  assign va = pu.in_PUAOperand;
  assign vb = pu.in_PUBOperand;
  assign vc = pu.in_PUCOperand;
  assign op = pu.in_PUType;

  // Return {sat, value}; mode 0 modulo, 1 unsigned->unsigned,
  // 2 signed->unsigned, 3 signed->signed.
  function automatic logic [8:0] pack_h(input logic [15:0] h, input logic [1:0] mode);
    logic [8:0] r;
    r = {1'b0, h[7:0]};
    case (mode)
      2'd1: if (h[15:8] != 8'd0) r = 9'h1FF;
      2'd2: begin
        if (h[15]) r = 9'h100;
        else if (h[14:8] != 7'd0) r = 9'h1FF;
      end
      2'd3: if (h[15:7] != 9'd0 && h[15:7] != 9'h1FF) r = {1'b1, h[15] ? 8'h80 : 8'h7F};
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [16:0] pack_w(input logic [31:0] w, input logic [1:0] mode);
    logic [16:0] r;
    r = {1'b0, w[15:0]};
    case (mode)
      2'd1: if (w[31:16] != 16'd0) r = 17'h1FFFF;
      2'd2: begin
        if (w[31]) r = 17'h10000;
        else if (w[30:16] != 15'd0) r = 17'h1FFFF;
      end
      2'd3: if (w[31:15] != 17'd0 && w[31:15] != 17'h1FFFF)
              r = {1'b1, w[31] ? 16'h8000 : 16'h7FFF};
      default: ;
    endcase
    return r;
  endfunction

  always_comb begin
    res       = '0;
    sat       = 1'b0;
    supported = 1'b1;
    ph        = '0;
    pw        = '0;
    hx        = '0;
    ab        = {va, vb};
    ab_sh     = ab << {vc[3:0], 3'b000};
    sat_op    = (op >= 6'd21) && (op <= 6'd26);
    case (op)
      6'd19, 6'd20: pk_mode = 2'd0;
      6'd21, 6'd22: pk_mode = 2'd1;
      6'd23, 6'd24: pk_mode = 2'd2;
      default:      pk_mode = 2'd3;
    endcase

    case (op)
      6'd0: for (int k = 0; k < 16; k++)
              res[127-8*k -: 8] = ab[255-8*int'(vc[124-8*k -: 5]) -: 8];
      6'd1: res = (va & ~vc) | (vb & vc);
      6'd2: for (int i = 0; i < 8; i++) begin
              res[127-16*i -: 8] = va[127-8*i -: 8];
              res[119-16*i -: 8] = vb[127-8*i -: 8];
            end
      6'd3: for (int i = 0; i < 4; i++) begin
              res[127-32*i -: 16] = va[127-16*i -: 16];
              res[111-32*i -: 16] = vb[127-16*i -: 16];
            end
      6'd4: for (int i = 0; i < 2; i++) begin
              res[127-64*i -: 32] = va[127-32*i -: 32];
              res[95-64*i -: 32]  = vb[127-32*i -: 32];
            end
      6'd5: for (int i = 0; i < 8; i++) begin
              res[127-16*i -: 8] = va[63-8*i -: 8];
              res[119-16*i -: 8] = vb[63-8*i -: 8];
            end
      6'd6: for (int i = 0; i < 4; i++) begin
              res[127-32*i -: 16] = va[63-16*i -: 16];
              res[111-32*i -: 16] = vb[63-16*i -: 16];
            end
      6'd7: for (int i = 0; i < 2; i++) begin
              res[127-64*i -: 32] = va[63-32*i -: 32];
              res[95-64*i -: 32]  = vb[63-32*i -: 32];
            end
      6'd8:  res = {16{vb[127-8*int'(vc[3:0]) -: 8]}};
      6'd9:  res = {8{vb[127-16*int'(vc[2:0]) -: 16]}};
      6'd10: res = {4{vb[127-32*int'(vc[1:0]) -: 32]}};
      6'd11: res = {16{{3{vc[4]}}, vc[4:0]}};
      6'd12: res = {8{{11{vc[4]}}, vc[4:0]}};
      6'd13: res = {4{{27{vc[4]}}, vc[4:0]}};
      6'd14: res = ab_sh[255:128];
      6'd15: res = va << vb[2:0];
      6'd16: res = va >> vb[2:0];
      6'd17: res = va << {vb[6:3], 3'b000};
      6'd18: res = va >> {vb[6:3], 3'b000};
      6'd19, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25, 6'd26: begin
        // Odd codes pack halves to bytes, even codes pack words to halves.
        if (op[0]) begin
          for (int i = 0; i < 8; i++) begin
            ph = pack_h(va[127-16*i -: 16], pk_mode);
            res[127-8*i -: 8] = ph[7:0];
            sat = sat | ph[8];
            ph = pack_h(vb[127-16*i -: 16], pk_mode);
            res[63-8*i -: 8] = ph[7:0];
            sat = sat | ph[8];
          end
        end else begin
          for (int i = 0; i < 4; i++) begin
            pw = pack_w(va[127-32*i -: 32], pk_mode);
            res[127-16*i -: 16] = pw[15:0];
            sat = sat | pw[16];
            pw = pack_w(vb[127-32*i -: 32], pk_mode);
            res[63-16*i -: 16] = pw[15:0];
            sat = sat | pw[16];
          end
        end
      end
`ifdef PU_PIXEL_OPS_EN
      6'd27: for (int i = 0; i < 4; i++) begin
               res[127-16*i -: 16] = {va[127-32*i-7], va[127-32*i-8 -: 5],
                                      va[127-32*i-16 -: 5], va[127-32*i-24 -: 5]};
               res[63-16*i -: 16]  = {vb[127-32*i-7], vb[127-32*i-8 -: 5],
                                      vb[127-32*i-16 -: 5], vb[127-32*i-24 -: 5]};
             end
      6'd32, 6'd33: for (int i = 0; i < 4; i++) begin
               hx = op[0] ? vb[63-16*i -: 16] : vb[127-16*i -: 16];
               res[127-32*i -: 32] = {{8{hx[15]}}, 3'b000, hx[14:10],
                                      3'b000, hx[9:5], 3'b000, hx[4:0]};
             end
`endif
      6'd28: for (int i = 0; i < 8; i++)
               res[127-16*i -: 16] = {{8{vb[127-8*i]}}, vb[127-8*i -: 8]};
      6'd29: for (int i = 0; i < 4; i++)
               res[127-32*i -: 32] = {{16{vb[127-16*i]}}, vb[127-16*i -: 16]};
      6'd30: for (int i = 0; i < 8; i++)
               res[127-16*i -: 16] = {{8{vb[63-8*i]}}, vb[63-8*i -: 8]};
      6'd31: for (int i = 0; i < 4; i++)
               res[127-32*i -: 32] = {{16{vb[63-16*i]}}, vb[63-16*i -: 16]};
      default: supported = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      tgt_q     <= '0;
      res_q     <= '0;
      vscr_en_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      en_q      <= pu.in_PU_cs & supported;
      tgt_q     <= (pu.in_PU_cs & supported) ? pu.in_PUTargetRegister : 5'd0;
      res_q     <= (pu.in_PU_cs & supported) ? res : 128'd0;
      vscr_en_q <= pu.in_PU_cs & supported & sat_op;
      sat_q     <= pu.in_PU_cs & supported & sat_op & sat;
    end
  end

  assign pu.out_PUTargetRegisterEnable = en_q;
  assign pu.out_PUTargetRegister       = tgt_q;
  assign pu.out_PUResult               = res_q;
  assign pu.out_PUtoVSCREnable         = vscr_en_q;
  assign pu.out_PUtoVSCR               = {31'd0, sat_q};
  assign pu.out_PUTargetRegisterPipe   = pu.in_PU_cs ? pu.in_PUTargetRegister : 5'd0;

endmodule

`default_nettype wire

// File: tb/tb_permute_unit_core.sv
// ----------------------------------------------------------------------------
// tb_permute_unit_core : scoreboard bench with an element-level reference model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_permute_unit_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  permute_unit_core_if pu_if ();
  permute_unit_core dut (.clk(clk), .rst_n(rst_n), .pu(pu_if));

  typedef struct {
    logic         en;
    logic [4:0]   tgt;
    logic [127:0] res;
    logic         vscr_en;
    logic [31:0]  vscr;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Element i (big-endian) of width w bytes
  function automatic longint unsigned get_e(input logic [127:0] v, input int w, input int i);
    logic [127:0] t;
    t = v >> (128 - 8*w*(i+1));
    return t[63:0] & ((64'd1 << (8*w)) - 1);
  endfunction

  function automatic logic [127:0] put_e(input logic [127:0] v, input int w, input int i,
                                         input longint unsigned x);
    logic [127:0] t;
    t = 128'(x & ((64'd1 << (8*w)) - 1));
    return v | (t << (128 - 8*w*(i+1)));
  endfunction

  function automatic longint sx(input longint unsigned x, input int bits);
    longint unsigned lim;
    lim = 64'd1 << (bits - 1);
    return (x >= lim) ? longint'(x) - longint'(lim << 1) : longint'(x);
  endfunction

  function automatic exp_t model(input int op, input logic [127:0] a, b, c, input logic [4:0] tgt);
    exp_t e;
    logic [127:0] r;
    bit ok, sat;
    int n, w, base, cnt, kind, idx;
    longint unsigned raw, o, p;
    longint s, umax, smax, smin;
    r = '0; ok = 1; sat = 0;
    if (op == 0) begin
      for (int k = 0; k < 16; k++) begin
        idx = int'(get_e(c, 1, k) & 31);
        r = put_e(r, 1, k, idx < 16 ? get_e(a, 1, idx) : get_e(b, 1, idx - 16));
      end
    end else if (op == 1) begin
      r = (a & ~c) | (b & c);
    end else if (op >= 2 && op <= 7) begin
      w = (op == 2 || op == 5) ? 1 : (op == 3 || op == 6) ? 2 : 4;
      n = 8 / w;
      base = (op >= 5) ? n : 0;
      for (int i = 0; i < n; i++) begin
        r = put_e(r, w, 2*i, get_e(a, w, base + i));
        r = put_e(r, w, 2*i + 1, get_e(b, w, base + i));
      end
    end else if (op >= 8 && op <= 10) begin
      w = 1 << (op - 8);
      cnt = 16 / w;
      raw = get_e(b, w, int'(get_e(c, 1, 15) & 31) % cnt);
      for (int i = 0; i < cnt; i++) r = put_e(r, w, i, raw);
    end else if (op >= 11 && op <= 13) begin
      w = 1 << (op - 11);
      s = sx(get_e(c, 1, 15) & 31, 5);
      for (int i = 0; i < 16 / w; i++) r = put_e(r, w, i, longint'(s));
    end else if (op == 14) begin
      n = int'(get_e(c, 1, 15) & 15);
      for (int k = 0; k < 16; k++)
        r = put_e(r, 1, k, (k + n < 16) ? get_e(a, 1, k + n) : get_e(b, 1, k + n - 16));
    end else if (op == 15 || op == 16) begin
      n = int'(get_e(b, 1, 15) & 7);
      for (int j = 0; j < 128; j++) begin
        if (op == 15) r[127-j] = (j + n < 128) ? a[127-j-n] : 1'b0;
        else          r[127-j] = (j - n >= 0)  ? a[127-j+n] : 1'b0;
      end
    end else if (op == 17 || op == 18) begin
      n = int'((get_e(b, 1, 15) >> 3) & 15);
      for (int k = 0; k < 16; k++) begin
        if (op == 17) r = put_e(r, 1, k, (k + n < 16) ? get_e(a, 1, k + n) : 0);
        else          r = put_e(r, 1, k, (k >= n) ? get_e(a, 1, k - n) : 0);
      end
    end else if (op >= 19 && op <= 26) begin
      w = (op % 2 == 1) ? 2 : 4;
      kind = (op - 19) / 2;
      cnt = 16 / w;
      umax = (longint'(1) << (4*w)) - 1;
      smax = (longint'(1) << (4*w - 1)) - 1;
      smin = -(longint'(1) << (4*w - 1));
      for (int i = 0; i < 2*cnt; i++) begin
        raw = (i < cnt) ? get_e(a, w, i) : get_e(b, w, i - cnt);
        s = sx(raw, 8*w);
        o = raw;
        if (kind == 1) begin
          if (longint'(raw) > umax) begin o = umax; sat = 1; end
        end else if (kind == 2) begin
          if (s < 0) begin o = 0; sat = 1; end
          else if (s > umax) begin o = umax; sat = 1; end
        end else if (kind == 3) begin
          if (s > smax) begin s = smax; sat = 1; end
          else if (s < smin) begin s = smin; sat = 1; end
          o = longint'(s);
        end
        r = put_e(r, w/2, i, o);
      end
    end else if (op >= 28 && op <= 31) begin
      w = (op % 2 == 0) ? 1 : 2;
      base = (op >= 30) ? 8 / w : 0;
      for (int i = 0; i < 8 / w; i++)
        r = put_e(r, 2*w, i, longint'(sx(get_e(b, w, base + i), 8*w)));
`ifdef PU_PIXEL_OPS_EN
    end else if (op == 27) begin
      for (int i = 0; i < 8; i++) begin
        raw = (i < 4) ? get_e(a, 4, i) : get_e(b, 4, i - 4);
        p = (((raw >> 24) & 1) << 15) | (((raw >> 19) & 31) << 10) |
            (((raw >> 11) & 31) << 5) | ((raw >> 3) & 31);
        r = put_e(r, 2, i, p);
      end
    end else if (op == 32 || op == 33) begin
      for (int i = 0; i < 4; i++) begin
        p = get_e(b, 2, (op == 33 ? 4 : 0) + i);
        o = ((((p >> 15) & 1) != 0 ? 64'hFF : 64'h0) << 24) | (((p >> 10) & 31) << 16) |
            (((p >> 5) & 31) << 8) | (p & 31);
        r = put_e(r, 4, i, o);
      end
`endif
    end else begin
      ok = 0;
    end
    e.en      = ok;
    e.tgt     = ok ? tgt : 5'd0;
    e.res     = ok ? r : 128'd0;
    e.vscr_en = ok && op >= 21 && op <= 26;
    e.vscr    = {31'd0, e.vscr_en && sat};
    return e;
  endfunction

  task automatic issue(input logic rst, input logic cs, input logic [5:0] op,
                       input logic [127:0] a, b, c, input logic [4:0] tgt);
    exp_t e;
    @(negedge clk);
    rst_n                     = rst;
    pu_if.in_PU_cs            = cs;
    pu_if.in_PUType           = op;
    pu_if.in_PUAOperand       = a;
    pu_if.in_PUBOperand       = b;
    pu_if.in_PUCOperand       = c;
    pu_if.in_PUTargetRegister = tgt;
    if (rst && cs) e = model(int'(op), a, b, c, tgt);
    else begin
      e.en = 0; e.tgt = '0; e.res = '0; e.vscr_en = 0; e.vscr = '0;
    end
    q.push_back(e);
    #1 chk("pipe_target", 128'(pu_if.out_PUTargetRegisterPipe), 128'(cs ? tgt : 5'd0));
  endtask

  // Monitor: every edge that completes a driven cycle yields one expected entry
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("enable", 128'(pu_if.out_PUTargetRegisterEnable), 128'(e.en));
        chk("result", pu_if.out_PUResult, e.res);
        chk("vscr_enable", 128'(pu_if.out_PUtoVSCREnable), 128'(e.vscr_en));
        chk("vscr", 128'(pu_if.out_PUtoVSCR), 128'(e.vscr));
        if (e.en) chk("target", 128'(pu_if.out_PUTargetRegister), 128'(e.tgt));
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] sa, sb, sc, ra, rb, rc;
    logic [5:0] rop;
    int guard;
    pu_if.in_PU_cs = 0; pu_if.in_PUType = '0; pu_if.in_PUAOperand = '0;
    pu_if.in_PUBOperand = '0; pu_if.in_PUCOperand = '0; pu_if.in_PUTargetRegister = '0;
    for (int k = 0; k < 16; k++) begin
      sa[127-8*k -: 8] = 8'(k);
      sb[127-8*k -: 8] = 8'(k + 16);
      sc[127-8*k -: 8] = 8'(31 - k);
    end

    issue(0, 0, 6'd0, '0, '0, '0, 5'd0);
    issue(0, 1, 6'd0, sa, sb, sc, 5'd7);             // reset beats issue
    issue(1, 1, 6'd0, sa, sb, sc, 5'd3);             // vperm reversal
    issue(1, 1, 6'd11, rnd128(), rnd128(), 128'h1F, 5'd4);
    rb = rnd128(); rb[63:32] = 32'hDEADBEEF;
    issue(1, 1, 6'd10, rnd128(), rb, 128'h2, 5'd5);
    issue(1, 1, 6'd25, {8{16'h7FFF}}, {8{16'h0001}}, '0, 5'd6);
    issue(1, 1, 6'd14, sa, sb, 128'h4, 5'd8);
    issue(1, 1, 6'd40, sa, sb, sc, 5'd9);
    issue(1, 0, 6'd1, sa, sb, sc, 5'd9);
    issue(1, 1, 6'd2, sa, sb, sc, 5'd12);            // back-to-back pair
    issue(1, 1, 6'd1, sa, sb, sc, 5'd13);
    issue(1, 1, 6'd27, rnd128(), rnd128(), '0, 5'd14);
    issue(1, 1, 6'd32, '0, rnd128(), '0, 5'd15);
    issue(1, 1, 6'd33, '0, rnd128(), '0, 5'd16);
    issue(1, 1, 6'd21, {8{16'h00FF}}, {8{16'h0042}}, '0, 5'd17);

    for (int t = 0; t < 700; t++) begin
      rop = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(34, 63)) : 6'($urandom_range(0, 33));
      ra = rnd128(); rb = rnd128(); rc = rnd128();
      if ($urandom_range(0, 2) == 0) begin
        ra &= {8{16'h007F}} | {4{32'h00007FFF}};
        rb &= {8{16'h007F}} | {4{32'h00007FFF}};
      end
      issue(1, ($urandom_range(0, 4) != 0), rop, ra, rb, rc, 5'($urandom));
    end
    issue(1, 0, 6'd0, '0, '0, '0, 5'd0);

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", 128'(q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
